// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, address generation and an optional iterative MUL/DIVU/REMU unit.
// The iterative unit is built only when EX_MULDIV_EN is defined; otherwise ops 16-18 complete as illegal.
module ex_stage #(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            EX_valid,
    input  logic [4:0]      EX_ALU_OP,
    input  logic [XLEN-1:0] EX_muxA,
    input  logic [XLEN-1:0] EX_muxB,
    input  logic [15:0]     EX_IMMEDIATE,
    input  logic            EX_DM_ADDR_SEL,
    input  logic            EX_DM_WE,
    input  logic            EX_ret_enable,
    input  logic            EX_NEXT_PC,
    output logic            ex_busy,
    output logic            MEM_valid,
    output logic [XLEN-1:0] MEM_RESULT,
    output logic [XLEN-1:0] MEM_DM_ADDR,
    output logic [XLEN-1:0] MEM_DM_WDATA,
    output logic            MEM_DM_WE,
    output logic            MEM_ret_enable,
    output logic            MEM_NEXT_PC,
    output logic            MEM_illegal
);
    localparam int SHW = $clog2(XLEN);

    if (MD_CYCLES != XLEN) begin : g_cfg_check
        $error("ex_stage: MD_CYCLES must equal XLEN");
    end

    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic [XLEN-1:0] agen;
    logic [SHW-1:0]  shamt;

    assign shamt = EX_muxB[SHW-1:0];
    assign agen  = EX_muxA + {{(XLEN-16){EX_IMMEDIATE[15]}}, EX_IMMEDIATE};

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (EX_ALU_OP)
            5'd0:    alu_res = EX_muxA + EX_muxB;
            5'd1:    alu_res = EX_muxA - EX_muxB;
            5'd2:    alu_res = EX_muxA & EX_muxB;
            5'd3:    alu_res = EX_muxA | EX_muxB;
            5'd4:    alu_res = EX_muxA ^ EX_muxB;
            5'd5:    alu_res = EX_muxA << shamt;
            5'd6:    alu_res = EX_muxA >> shamt;
            5'd7:    alu_res = $unsigned($signed(EX_muxA) >>> shamt);
            5'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(EX_muxA) < $signed(EX_muxB)};
            5'd9:    alu_res = {{(XLEN-1){1'b0}}, EX_muxA < EX_muxB};
            5'd10:   alu_res = EX_muxB;
            5'd11:   alu_res = {{(XLEN-16){1'b0}}, EX_IMMEDIATE} << 16;
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef EX_MULDIV_EN
    // state | meaning
    // IDLE  | accepting instructions; single-cycle ops complete here
    // CALC  | one MUL shift-add or restoring-divide step per edge
    // DONE  | result ready, written to MEM_* on the next edge
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
    localparam int CW = $clog2(MD_CYCLES + 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [4:0]      md_op;
    logic [XLEN-1:0] md_acc;   // MUL accumulator / divide remainder
    logic [XLEN-1:0] md_opd;   // MUL multiplicand / divisor
    logic [XLEN-1:0] md_aux;   // MUL multiplier / dividend shifting into quotient
    logic [XLEN-1:0] h_agen, h_wdata;
    logic            h_sel, h_we, h_ret, h_npc;
    logic            is_md_op;
    logic [XLEN:0]   div_trial, div_diff;
    logic            div_ge;
    logic [XLEN-1:0] md_res;

    assign is_md_op  = (EX_ALU_OP == 5'd16) || (EX_ALU_OP == 5'd17) || (EX_ALU_OP == 5'd18);
    assign ex_busy   = rst_n & ((state == S_CALC) | ((state == S_IDLE) & EX_valid & is_md_op));
    assign div_trial = {md_acc, md_aux[XLEN-1]};
    assign div_diff  = div_trial - {1'b0, md_opd};
    assign div_ge    = div_trial >= {1'b0, md_opd};
    assign md_res    = (md_op == 5'd17) ? md_aux : md_acc;
`else
    assign ex_busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MEM_valid      <= 1'b0;
            MEM_RESULT     <= '0;
            MEM_DM_ADDR    <= '0;
            MEM_DM_WDATA   <= '0;
            MEM_DM_WE      <= 1'b0;
            MEM_ret_enable <= 1'b0;
            MEM_NEXT_PC    <= 1'b0;
            MEM_illegal    <= 1'b0;
`ifdef EX_MULDIV_EN
            state  <= S_IDLE;
            cnt    <= '0;
            md_op  <= '0;
            md_acc <= '0;
            md_opd <= '0;
            md_aux <= '0;
            h_agen <= '0;
            h_wdata <= '0;
            h_sel  <= 1'b0;
            h_we   <= 1'b0;
            h_ret  <= 1'b0;
            h_npc  <= 1'b0;
`endif
        end else if (flush) begin
            MEM_valid      <= 1'b0;
            MEM_DM_WE      <= 1'b0;
            MEM_ret_enable <= 1'b0;
            MEM_illegal    <= 1'b0;
`ifdef EX_MULDIV_EN
            state <= S_IDLE;
            cnt   <= '0;
`endif
        end
`ifdef EX_MULDIV_EN
        else if (state == S_CALC) begin
            if (md_op == 5'd16) begin
                if (md_aux[0]) md_acc <= md_acc + md_opd;
                md_opd <= md_opd << 1;
                md_aux <= md_aux >> 1;
            end else begin
                md_acc <= div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
                md_aux <= {md_aux[XLEN-2:0], div_ge};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(MD_CYCLES - 1)) state <= S_DONE;
        end else if (state == S_DONE) begin
            MEM_valid      <= 1'b1;
            MEM_RESULT     <= md_res;
            MEM_DM_ADDR    <= h_sel ? h_agen : md_res;
            MEM_DM_WDATA   <= h_wdata;
            MEM_DM_WE      <= h_we;
            MEM_ret_enable <= h_ret;
            MEM_NEXT_PC    <= h_npc;
            MEM_illegal    <= 1'b0;
            state          <= S_IDLE;
        end else if (EX_valid && is_md_op) begin
            md_op  <= EX_ALU_OP;
            md_acc <= '0;
            md_opd <= (EX_ALU_OP == 5'd16) ? EX_muxA : EX_muxB;
            md_aux <= (EX_ALU_OP == 5'd16) ? EX_muxB : EX_muxA;
            h_agen <= agen;
            h_wdata <= EX_muxB;
            h_sel  <= EX_DM_ADDR_SEL;
            h_we   <= EX_DM_WE;
            h_ret  <= EX_ret_enable;
            h_npc  <= EX_NEXT_PC;
            cnt    <= '0;
            state  <= S_CALC;
            MEM_valid      <= 1'b0;
            MEM_DM_WE      <= 1'b0;
            MEM_ret_enable <= 1'b0;
            MEM_illegal    <= 1'b0;
        end
`endif
        else if (EX_valid) begin
            MEM_valid      <= 1'b1;
            MEM_RESULT     <= alu_res;
            MEM_DM_ADDR    <= EX_DM_ADDR_SEL ? agen : alu_res;
            MEM_DM_WDATA   <= EX_muxB;
            MEM_DM_WE      <= EX_DM_WE;
            MEM_ret_enable <= EX_ret_enable;
            MEM_NEXT_PC    <= EX_NEXT_PC;
            MEM_illegal    <= alu_ill;
        end else begin
            MEM_valid      <= 1'b0;
            MEM_DM_WE      <= 1'b0;
            MEM_ret_enable <= 1'b0;
            MEM_illegal    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; iterative-op scenarios follow EX_MULDIV_EN.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n, flush, v;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [15:0] imm;
    logic        sel, we, ret, npc;
    logic        ex_busy, MEM_valid, MEM_DM_WE, MEM_ret_enable, MEM_NEXT_PC, MEM_illegal;
    logic [31:0] MEM_RESULT, MEM_DM_ADDR, MEM_DM_WDATA;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32), .MD_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .EX_valid(v), .EX_ALU_OP(op),
        .EX_muxA(a), .EX_muxB(b), .EX_IMMEDIATE(imm), .EX_DM_ADDR_SEL(sel),
        .EX_DM_WE(we), .EX_ret_enable(ret), .EX_NEXT_PC(npc), .ex_busy(ex_busy),
        .MEM_valid(MEM_valid), .MEM_RESULT(MEM_RESULT), .MEM_DM_ADDR(MEM_DM_ADDR),
        .MEM_DM_WDATA(MEM_DM_WDATA), .MEM_DM_WE(MEM_DM_WE), .MEM_ret_enable(MEM_ret_enable),
        .MEM_NEXT_PC(MEM_NEXT_PC), .MEM_illegal(MEM_illegal)
    );

    task automatic drive(input logic [4:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [15:0] ii, input logic s, input logic w,
                         input logic r, input logic n);
        v = 1'b1; op = o; a = aa; b = bb; imm = ii; sel = s; we = w; ret = r; npc = n;
    endtask

    task automatic bubble;
        v = 1'b0; we = 1'b0; ret = 1'b0; npc = 1'b0; sel = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0;
        drive(5'd16, 32'd7, 32'd6, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        checks++;
        if (ex_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", ex_busy);
        end
        bubble();
        checks++;
        if ({MEM_valid, MEM_DM_WE, MEM_ret_enable, MEM_NEXT_PC, MEM_illegal} !== 5'b0 ||
            MEM_RESULT !== 32'd0 || MEM_DM_ADDR !== 32'd0 || MEM_DM_WDATA !== 32'd0) begin
            errors++; $display("FAIL reset_outputs: valid=%b res=%h addr=%h wdata=%h want all 0",
                               MEM_valid, MEM_RESULT, MEM_DM_ADDR, MEM_DM_WDATA);
        end
        #1 rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (MEM_valid !== 1'b0 || ex_busy !== 1'b0 || MEM_RESULT !== 32'd0) begin
            errors++; $display("FAIL reset_release_idle: valid=%b busy=%b res=%h want 0/0/0",
                               MEM_valid, ex_busy, MEM_RESULT);
        end
    endtask

    task automatic test_alu;
        vec_t vt[14];
        vt[0]  = '{5'd0,  32'hFFFF_FFFF, 32'd2,         16'h0,    32'h0000_0001};
        vt[1]  = '{5'd1,  32'd5,         32'd7,         16'h0,    32'hFFFF_FFFE};
        vt[2]  = '{5'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 16'h0,    32'hF000_F000};
        vt[3]  = '{5'd3,  32'h0000_0F00, 32'h0000_00F0, 16'h0,    32'h0000_0FF0};
        vt[4]  = '{5'd4,  32'hFFFF_0000, 32'hFF00_FF00, 16'h0,    32'h00FF_FF00};
        vt[5]  = '{5'd5,  32'd1,         32'h0000_0023, 16'h0,    32'h0000_0008};
        vt[6]  = '{5'd6,  32'h8000_0000, 32'd4,         16'h0,    32'h0800_0000};
        vt[7]  = '{5'd7,  32'h8000_0000, 32'd4,         16'h0,    32'hF800_0000};
        vt[8]  = '{5'd8,  32'hFFFF_FFFF, 32'd1,         16'h0,    32'h0000_0001};
        vt[9]  = '{5'd9,  32'hFFFF_FFFF, 32'd1,         16'h0,    32'h0000_0000};
        vt[10] = '{5'd10, 32'd0,         32'h1234_ABCD, 16'h0,    32'h1234_ABCD};
        vt[11] = '{5'd11, 32'd0,         32'd0,         16'h1234, 32'h1234_0000};
        vt[12] = '{5'd5,  32'd1,         32'd31,        16'h0,    32'h8000_0000};
        vt[13] = '{5'd8,  32'd1,         32'hFFFF_FFFF, 16'h0,    32'h0000_0000};
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].op, vt[i].a, vt[i].b, vt[i].imm, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            checks++;
            if (MEM_RESULT !== vt[i].exp || MEM_DM_ADDR !== vt[i].exp || MEM_valid !== 1'b1 ||
                MEM_illegal !== 1'b0) begin
                errors++; $display("FAIL alu_vec%0d op=%0d: res=%h addr=%h valid=%b ill=%b want res=addr=%h valid=1 ill=0",
                                   i, vt[i].op, MEM_RESULT, MEM_DM_ADDR, MEM_valid, MEM_illegal, vt[i].exp);
            end
        end
    endtask

    task automatic test_store_and_bubble;
        drive(5'd0, 32'h0000_0100, 32'h0000_DEAD, 16'hFFFC, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        checks++;
        if (MEM_DM_ADDR !== 32'h0000_00FC || MEM_DM_WDATA !== 32'h0000_DEAD || MEM_DM_WE !== 1'b1 ||
            MEM_RESULT !== 32'h0000_DFAD || MEM_ret_enable !== 1'b1 || MEM_NEXT_PC !== 1'b1 || MEM_valid !== 1'b1) begin
            errors++; $display("FAIL store: addr=%h wdata=%h we=%b res=%h ret=%b npc=%b want 000000fc/0000dead/1/0000dfad/1/1",
                               MEM_DM_ADDR, MEM_DM_WDATA, MEM_DM_WE, MEM_RESULT, MEM_ret_enable, MEM_NEXT_PC);
        end
        bubble();
        tick();
        checks++;
        if (MEM_valid !== 1'b0 || MEM_DM_WE !== 1'b0 || MEM_ret_enable !== 1'b0 || MEM_illegal !== 1'b0 ||
            MEM_RESULT !== 32'h0000_DFAD || MEM_DM_ADDR !== 32'h0000_00FC || MEM_DM_WDATA !== 32'h0000_DEAD) begin
            errors++; $display("FAIL bubble: valid=%b we=%b ret=%b res=%h addr=%h want 0/0/0 hold dfad/fc",
                               MEM_valid, MEM_DM_WE, MEM_ret_enable, MEM_RESULT, MEM_DM_ADDR);
        end
    endtask

    task automatic test_illegal;
        logic [4:0] ops[2];
        ops[0] = 5'd31; ops[1] = 5'd12;
        for (int i = 0; i < 2; i++) begin
            drive(5'd0, 32'd1, 32'd1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            drive(ops[i], 32'd5, 32'd3, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            checks++;
            if (MEM_illegal !== 1'b1 || MEM_RESULT !== 32'd0 || MEM_valid !== 1'b1) begin
                errors++; $display("FAIL illegal_op%0d: ill=%b res=%h valid=%b want 1/0/1",
                                   ops[i], MEM_illegal, MEM_RESULT, MEM_valid);
            end
        end
    endtask

    task automatic test_flush_single;
        drive(5'd0, 32'd2, 32'd3, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 32'd4, 32'd4, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (MEM_valid !== 1'b0 || MEM_DM_WE !== 1'b0 || MEM_ret_enable !== 1'b0 || MEM_RESULT !== 32'd5) begin
            errors++; $display("FAIL flush_single: valid=%b we=%b ret=%b res=%h want 0/0/0 hold 5",
                               MEM_valid, MEM_DM_WE, MEM_ret_enable, MEM_RESULT);
        end
        bubble();
        tick();
    endtask

`ifdef EX_MULDIV_EN
    task automatic run_md(input logic [4:0] o, input logic [31:0] aa, input logic [31:0] bb,
                          output logic timed_out);
        int n;
        n = 0;
        drive(o, aa, bb, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        while (ex_busy === 1'b1 && n < 40) begin
            tick(); n++;
        end
        timed_out = (n >= 40);
        tick();
    endtask

    task automatic test_mul;
        int busy_cyc, cyc;
        logic early_valid;
        busy_cyc = 0; cyc = 0; early_valid = 1'b0;
        drive(5'd16, 32'd7, 32'd6, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        while (ex_busy === 1'b1 && cyc < 100) begin
            busy_cyc++;
            if (cyc > 0 && MEM_valid !== 1'b0) early_valid = 1'b1;
            tick(); cyc++;
        end
        checks++;
        if (busy_cyc != 33) begin
            errors++; $display("FAIL mul_busy_len: got %0d cycles want 33", busy_cyc);
        end
        checks++;
        if (early_valid || MEM_valid !== 1'b0) begin
            errors++; $display("FAIL mul_valid_low: valid seen high during busy (now %b) want 0", MEM_valid);
        end
        drive(5'd0, 32'd3, 32'd4, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (MEM_RESULT !== 32'd42 || MEM_valid !== 1'b1 || MEM_illegal !== 1'b0) begin
            errors++; $display("FAIL mul_result: res=%h valid=%b ill=%b want 0000002a/1/0", MEM_RESULT, MEM_valid, MEM_illegal);
        end
        tick();
        checks++;
        if (MEM_RESULT !== 32'd7 || MEM_valid !== 1'b1) begin
            errors++; $display("FAIL mul_next_add: res=%h valid=%b want 00000007/1", MEM_RESULT, MEM_valid);
        end
        bubble();
        tick();
    endtask

    task automatic test_div;
        logic to;
        run_md(5'd17, 32'd100, 32'd0, to);
        checks++;
        if (to || MEM_RESULT !== 32'hFFFF_FFFF || MEM_valid !== 1'b1) begin
            errors++; $display("FAIL divu_by_zero: res=%h valid=%b timeout=%b want ffffffff/1/0", MEM_RESULT, MEM_valid, to);
        end
        run_md(5'd18, 32'd100, 32'd7, to);
        checks++;
        if (to || MEM_RESULT !== 32'd2 || MEM_valid !== 1'b1) begin
            errors++; $display("FAIL remu: res=%h valid=%b timeout=%b want 00000002/1/0", MEM_RESULT, MEM_valid, to);
        end
        run_md(5'd17, 32'd100, 32'd7, to);
        checks++;
        if (to || MEM_RESULT !== 32'd14 || MEM_valid !== 1'b1) begin
            errors++; $display("FAIL divu: res=%h valid=%b timeout=%b want 0000000e/1/0", MEM_RESULT, MEM_valid, to);
        end
        run_md(5'd18, 32'd100, 32'd0, to);
        checks++;
        if (to || MEM_RESULT !== 32'd100) begin
            errors++; $display("FAIL remu_by_zero: res=%h timeout=%b want 00000064/0", MEM_RESULT, to);
        end
        bubble();
        tick();
    endtask

    task automatic test_flush_md;
        logic seen;
        seen = 1'b0;
        drive(5'd16, 32'd7, 32'd6, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bubble();
        checks++;
        if (MEM_valid !== 1'b0 || ex_busy !== 1'b0) begin
            errors++; $display("FAIL flush_md: valid=%b busy=%b want 0/0", MEM_valid, ex_busy);
        end
        repeat (40) begin
            tick();
            if (MEM_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL flush_md_late: valid rose after flush, want 0");
        end
        drive(5'd0, 32'd1, 32'd1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (MEM_RESULT !== 32'd2 || MEM_valid !== 1'b1) begin
            errors++; $display("FAIL flush_md_recover: res=%h valid=%b want 00000002/1", MEM_RESULT, MEM_valid);
        end
    endtask

    task automatic test_reset_mid;
        logic to;
        drive(5'd16, 32'd9, 32'd9, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        repeat (5) tick();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (MEM_RESULT !== 32'd0 || MEM_valid !== 1'b0 || ex_busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid: res=%h valid=%b busy=%b want 0/0/0", MEM_RESULT, MEM_valid, ex_busy);
        end
        bubble();
        #2 rst_n = 1'b1;
        repeat (40) tick();
        checks++;
        if (MEM_RESULT !== 32'd0 || MEM_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_discard: res=%h valid=%b want 0/0", MEM_RESULT, MEM_valid);
        end
        run_md(5'd16, 32'd3, 32'd5, to);
        checks++;
        if (to || MEM_RESULT !== 32'd15 || MEM_valid !== 1'b1) begin
            errors++; $display("FAIL reset_mid_rerun: res=%h valid=%b timeout=%b want 0000000f/1/0", MEM_RESULT, MEM_valid, to);
        end
        bubble();
        tick();
    endtask
`else
    task automatic test_nomd;
        for (int i = 16; i <= 18; i++) begin
            drive(5'(i), 32'd7, 32'd6, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            checks++;
            if (ex_busy !== 1'b0) begin
                errors++; $display("FAIL nomd_busy_op%0d: got %b want 0", i, ex_busy);
            end
            tick();
            checks++;
            if (MEM_illegal !== 1'b1 || MEM_RESULT !== 32'd0 || MEM_valid !== 1'b1 || ex_busy !== 1'b0) begin
                errors++; $display("FAIL nomd_op%0d: ill=%b res=%h valid=%b busy=%b want 1/0/1/0",
                                   i, MEM_illegal, MEM_RESULT, MEM_valid, ex_busy);
            end
        end
        bubble();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_store_and_bubble();
        test_illegal();
        test_flush_single();
`ifdef EX_MULDIV_EN
        test_mul();
        test_div();
        test_flush_md();
        test_reset_mid();
`else
        test_nomd();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage that consumes the ID/EX pipeline register outputs.
- Computes the ALU result and the data-memory address, then drives the EX/MEM-side registered outputs.
- Executes single-cycle ALU ops plus iterative multiply/divide, and holds the upstream ID/EX register through a busy (stall) signal while an iterative op runs.
- Sits between the ID/EX register and the data memory / writeback path.

Parameters:
- XLEN, 32, operand/result width.
- MD_CYCLES, 32, iteration count for MUL/DIVU/REMU (must equal XLEN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of current/in-flight instruction.
- EX_valid  in  1  the EX_* inputs hold a real instruction (0 = bubble).
- EX_ALU_OP  in  5  operation code.
- EX_muxA  in  XLEN  operand A.
- EX_muxB  in  XLEN  operand B / store data.
- EX_IMMEDIATE  in  16  immediate, sign-extended for address generation.
- EX_DM_ADDR_SEL  in  1  1: address = A + sext(imm); 0: address = ALU result.
- EX_DM_WE  in  1  store request.
- EX_ret_enable  in  1  return-instruction flag.
- EX_NEXT_PC  in  1  next-PC select flag.
- ex_busy  out  1  combinational stall to ID/EX; upstream holds its outputs while high.
- MEM_valid  out  1  registered; MEM_* carries a completed instruction.
- MEM_RESULT  out  XLEN  registered ALU/MD result.
- MEM_DM_ADDR  out  XLEN  registered memory address.
- MEM_DM_WDATA  out  XLEN  registered store data (B).
- MEM_DM_WE  out  1  registered store enable.
- MEM_ret_enable  out  1  registered.
- MEM_NEXT_PC  out  1  registered.
- MEM_illegal  out  1  registered; unsupported op completed.

Behaviour:
- Reset: every MEM_* output is 0, FSM is IDLE, counter is 0. ex_busy is 0 while rst_n is low.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA (shift by B[4:0])
  - 8 SLT (signed), 9 SLTU
  - 10 PASSB, 11 LUI (imm<<16)
  - 16 MUL (low XLEN bits), 17 DIVU, 18 REMU
  - Any other code: result 0, MEM_illegal=1.
- Arithmetic wraps modulo 2^XLEN; no overflow flag.
- Single-cycle op (IDLE, EX_valid=1): MEM_* loaded on the next edge, MEM_valid=1, ex_busy=0.
- Bubble (EX_valid=0, IDLE): MEM_valid, MEM_DM_WE, MEM_ret_enable, MEM_illegal go 0 at the next edge; MEM data outputs hold.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC on an edge with EX_valid=1 and op in {16,17,18}. Latch operands, counter=0.
  - CALC: one shift-add (MUL) or restoring-divide step per edge. After MD_CYCLES steps -> DONE.
  - DONE: on the next edge, MEM_* loaded with the result (MEM_valid=1) -> IDLE. Inputs are ignored in DONE (already consumed).
- ex_busy = (state==CALC) | (state==IDLE & EX_valid & op in {16,17,18}) | (state==DONE & 0).
  - ex_busy is high for 33 cycles and low in DONE, so ID/EX advances on the same edge the result is written.
  - Total: result appears 33 edges after the single-cycle case would.
- MEM_valid=0 on every edge spent in CALC and on the accepting edge.
- Divide by zero: DIVU returns all-ones; REMU returns A. No trap.
- flush=1: dominates all other inputs. Next edge: state->IDLE, counter cleared, MEM_valid/DM_WE/ret_enable/illegal=0. ex_busy deasserts in the cycle after the flush edge.
- Reset mid-CALC: immediate return to IDLE with all outputs 0; partial result discarded.
- MEM_DM_ADDR = DM_ADDR_SEL ? A + sext(IMMEDIATE) : result.

Optional Feature:
- Macro: EX_MULDIV_EN.
- Defined: ops 16-18 execute iteratively as above.
- Undefined:
  - Ops 16-18 are treated as unsupported: single-cycle, result 0, MEM_illegal=1.
  - ex_busy is constant 0; CALC/DONE states and the iteration datapath are not built.

Test Plan:
- Reset released, EX_valid=0 -> all MEM_* 0, ex_busy 0.
- ADD A=0xFFFFFFFF, B=2 -> next edge MEM_RESULT=0x00000001, MEM_valid=1.
- SRA A=0x80000000, B=4 -> 0xF8000000.
- SLT A=0xFFFFFFFF, B=1 -> 1; SLTU -> 0.
- Store with DM_ADDR_SEL=1, A=0x100, imm=0xFFFC, B=0xDEAD, DM_WE=1 -> MEM_DM_ADDR=0xFC, MEM_DM_WDATA=0xDEAD, MEM_DM_WE=1.
- EX_MULDIV_EN, MUL A=7, B=6 held while busy:
  - ex_busy high 33 cycles; MEM_valid=0 throughout.
  - MEM_RESULT=42, MEM_valid=1 at edge 34.
  - Next instruction ADD accepted the edge after.
- DIVU A=100, B=0 -> all-ones; REMU A=100, B=7 -> 2.
- Flush at iteration 10 -> IDLE, MEM_valid stays 0.
- rst_n low at iteration 5 -> immediate clear.
- Op 31 -> MEM_illegal=1, MEM_RESULT=0.
- Without EX_MULDIV_EN: op 16 -> MEM_illegal=1, ex_busy never asserts.
